chunked_adder: RTL and testbench
================================

Name: chunked_adder

Overview:
- Parametrised multi-cycle adder/subtractor; successor to the team's fixed 4-bit ripple-carry adder.
- Splits a WIDTH-bit operation into CHUNK-bit slices, processed LSB-first at one slice per clock.
- A registered carry links each slice to the next.
- valid/ready handshake on input and output; sits between operand-producing logic and a result consumer where a wide, single-cycle carry chain is too slow.

Parameters:
WIDTH, 16, operand/result width in bits
CHUNK, 4, bits added per cycle; must divide WIDTH exactly (NCHUNK = WIDTH/CHUNK, 1 <= CHUNK <= WIDTH)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous active-high reset
in_valid  input  1  operands present
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in (add) / borrow-in (subtract)
sub  input  1  0 = add, 1 = subtract
out_valid  output  1  result present
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
cout  output  1  carry-out of MSB slice
ovf  output  1  signed overflow (see Optional Feature)
zero  output  1  result == 0 (see Optional Feature)

Behaviour:
- Interface: single clock domain; reset is synchronous and active-high.
- Reset values: state IDLE, slice counter 0, carry register 0, sum 0, cout 0, ovf 0, zero 0, out_valid 0.
  - in_ready is 0 in any cycle reset is high.
- Arithmetic:
  - sub=0: {cout,sum} = a + b + cin.
  - sub=1: {cout,sum} = a + ~b + ~cin = a - b - cin; cout=1 means no borrow.
  - Operand B is inverted at capture when sub=1; initial carry = cin ^ sub.
  - Results are modulo 2^WIDTH.
- IDLE state:
  - in_ready=1, out_valid=0.
  - On in_valid & in_ready: latch a, (b or ~b), initial carry; clear slice counter; go to RUN.
- RUN state:
  - in_ready=0, out_valid=0.
  - Each cycle, slice k = bits [k*CHUNK +: CHUNK] of sum <= a_k + b_k + carry; carry <= slice carry-out; k increments.
  - After the slice k = NCHUNK-1 edge: cout <= final carry, flags updated, go to DONE.
  - Latency: out_valid first high exactly NCHUNK cycles after the accept cycle (CHUNK = WIDTH gives 1 cycle).
- DONE state:
  - out_valid=1, in_ready=0.
  - sum/cout/ovf/zero held stable until out_valid & out_ready, then go to IDLE.
  - in_valid is ignored outside IDLE; no overlap of operations.
  - New operands are accepted earliest one cycle after the output handshake.
- Partial results: sum bits of slices not yet computed are don't-care while out_valid=0; the bench checks sum only when out_valid=1.
- Reset mid-operation (RUN or DONE): operation aborted, no out_valid pulse, all registers return to reset values on that edge.
- Simultaneous events:
  - out_ready held high in DONE: handshake completes in the first DONE cycle.
  - in_valid asserted in the same cycle as reset: ignored.

Optional Feature:
- Macro: CHUNKED_ADDER_FLAGS_EN.
- Defined:
  - ovf = carry into MSB XOR carry out of MSB, i.e. two's-complement overflow of the final result, signed on the effective operation.
  - zero = (sum == 0).
  - Both registered with the final slice and valid with out_valid.
- Not defined:
  - ovf and zero are tied to 0.
  - No MSB-carry tracking or zero-detect logic is synthesised.
  - Ports remain present.

Test Plan:
1. WIDTH=16, CHUNK=4; a=0x1234, b=0x4321, cin=0, sub=0 -> sum=0x5555, cout=0; out_valid rises exactly 4 cycles after the accept cycle.
2. a=0xFFFF, b=0x0001, cin=0, sub=0 -> sum=0x0000, cout=1, zero=1 (flags on); carry ripples through all 4 slices.
3. a=0x0005, b=0x0007, cin=0, sub=1 -> sum=0xFFFE, cout=0 (borrow). Then a=0x0007, b=0x0005, cin=1, sub=1 -> sum=0x0001, cout=1.
4. a=0x7FFF, b=0x0001, add -> sum=0x8000, ovf=1, cout=0 (flags on); same case with macro undefined -> ovf=0, zero=0.
5. Backpressure: hold out_ready=0 for 3 cycles in DONE while driving in_valid with new operands -> sum/cout stable, in_ready=0, new operands not taken. out_ready=1 -> IDLE next cycle, then accept.
6. Assert reset for one cycle during RUN at slice 2 -> out_valid never asserts for that operation; in_ready=1 the cycle after reset drops; following op a=0x0001, b=0x0001 -> sum=0x0002.

Source files
------------

// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle WIDTH-bit adder/subtractor, CHUNK bits per clock,
// LSB slice first, with a registered carry linking consecutive slices.
// Optional flags (signed overflow, zero) are built only when the macro
// CHUNKED_ADDER_FLAGS_EN is defined; otherwise ovf/zero are tied low.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. in_ready is high only in IDLE (and never while reset is high);
// out_valid is high only in DONE, and sum/cout/ovf/zero stay stable there
// until out_ready is seen. The producer must hold operands while in_valid
// is high and in_ready is low; one operation is in flight at a time.
module chunked_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic [1:0]       dbg_state_o
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST_K = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [CHUNK-1:0] a_sl, b_sl;
  logic [CHUNK:0]   slice_res;
  int               base;

`ifdef CHUNKED_ADDER_FLAGS_EN
  logic ovf_q, ovf_d;
  logic zero_q, zero_d;
`endif

  // Current slice operands and their CHUNK-bit sum with the stored carry.
  always_comb begin
    base      = int'(cnt_q) * CHUNK;
    a_sl      = a_q[base +: CHUNK];
    b_sl      = b_q[base +: CHUNK];
    slice_res = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry_q};
  end

  // Next-state logic: capture in IDLE, one slice per cycle in RUN, hold in DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef CHUNKED_ADDER_FLAGS_EN
    ovf_d   = ovf_q;
    zero_d  = zero_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = a;
          // Subtraction is a + ~b + ~cin, so invert B here and fold the
          // inversion of cin into the initial carry.
          b_d     = sub ? ~b : b;
          carry_d = cin ^ sub;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[base +: CHUNK] = slice_res[CHUNK-1:0];
        carry_d = slice_res[CHUNK];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_K) begin
          cnt_d   = '0;
          cout_d  = slice_res[CHUNK];
          state_d = S_DONE;
`ifdef CHUNKED_ADDER_FLAGS_EN
          // Carry into the MSB is recovered as a^b^sum at that bit.
          ovf_d  = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ sum_d[WIDTH-1] ^ slice_res[CHUNK];
          zero_d = (sum_d == '0);
`endif
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef CHUNKED_ADDER_FLAGS_EN
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef CHUNKED_ADDER_FLAGS_EN
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
`endif
    end
  end

  assign in_ready    = (state_q == S_IDLE) && !reset;
  assign out_valid   = (state_q == S_DONE);
  assign sum         = sum_q;
  assign cout        = cout_q;
  assign dbg_state_o = state_q;
`ifdef CHUNKED_ADDER_FLAGS_EN
  assign ovf  = ovf_q;
  assign zero = zero_q;
`else
  assign ovf  = 1'b0;
  assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_chunked_adder.sv
// Testbench for chunked_adder (WIDTH=16, CHUNK=4): table of directed vectors
// plus hand-written sequences for backpressure and mid-operation reset.
module tb_chunked_adder;

  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int NCHUNK = WIDTH / CHUNK;
`ifdef CHUNKED_ADDER_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b;
  logic             cin, sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout, ovf, zero;
  logic [1:0]       dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [WIDTH:0] exp_q[$];

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_cout;
    logic             exp_ovf;   // value with flags enabled
    logic             exp_zero;  // value with flags enabled
  } vec_t;

  vec_t vecs[12];

  chunked_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .cin        (cin),
    .sub        (sub),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sum        (sum),
    .cout       (cout),
    .ovf        (ovf),
    .zero       (zero),
    .dbg_state_o(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: issue one operation from IDLE, wait for the result, consume it.
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                        input logic tcin, input logic tsub,
                        output logic [WIDTH-1:0] rsum, output logic rcout,
                        output logic rovf, output logic rzero, output int lat);
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("out_valid_reached", 32'(out_valid), 32'd1);
    rsum = sum; rcout = cout; rovf = ovf; rzero = zero;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_after_handshake", 32'({out_valid, in_ready}), 32'b01);
  endtask

  initial begin
    logic [WIDTH-1:0] r_sum;
    logic             r_cout, r_ovf, r_zero;
    logic [WIDTH:0]   exp;
    int               lat;
    int               pulses;

    vecs[0]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    vecs[10] = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};

    // Reset
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    tick(); tick();
    check("in_ready_during_reset", 32'(in_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_sum", 32'(sum), 32'd0);
    check("reset_flags", 32'({cout, ovf, zero}), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back({vecs[i].exp_cout, vecs[i].exp_sum});
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, r_sum, r_cout, r_ovf, r_zero, lat);
      exp = exp_q.pop_front();
      check($sformatf("vec%0d_sum", i), 32'(r_sum), 32'(exp[WIDTH-1:0]));
      check($sformatf("vec%0d_cout", i), 32'(r_cout), 32'(exp[WIDTH]));
      check($sformatf("vec%0d_ovf", i), 32'(r_ovf), 32'(FLAGS & vecs[i].exp_ovf));
      check($sformatf("vec%0d_zero", i), 32'(r_zero), 32'(FLAGS & vecs[i].exp_zero));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(NCHUNK));
    end

    // Backpressure: DONE held 3 cycles while new operands are offered.
    check("bp_in_ready_idle", 32'(in_ready), 32'd1);
    a = 16'hAAAA; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("bp_latency", 32'(lat), 32'(NCHUNK));
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("bp_hold%0d_sum", c), 32'(sum), 32'h0000BBBB);
      check($sformatf("bp_hold%0d_cout", c), 32'(cout), 32'd0);
      check($sformatf("bp_hold%0d_valid_ready", c), 32'({out_valid, in_ready}), 32'b10);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_released_idle", 32'({out_valid, in_ready}), 32'b01);
    run_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, r_sum, r_cout, r_ovf, r_zero, lat);
    check("bp_next_sum", 32'(r_sum), 32'h0000FFFE);
    check("bp_next_cout", 32'(r_cout), 32'd1);

    // Reset while slice 2 is being computed; in_valid high alongside reset.
    a = 16'h0FFF; b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    reset = 1'b1; in_valid = 1'b1;
    #1;
    check("rst_mid_in_ready", 32'(in_ready), 32'd0);
    tick();
    reset = 1'b0; in_valid = 1'b0;
    #1;
    check("rst_mid_in_ready_after", 32'(in_ready), 32'd1);
    check("rst_mid_cout", 32'(cout), 32'd0);
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid) pulses++;
      tick();
    end
    check("rst_mid_no_out_valid", 32'(pulses), 32'd0);
    check("rst_mid_still_idle", 32'(in_ready), 32'd1);
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, r_sum, r_cout, r_ovf, r_zero, lat);
    check("rst_next_sum", 32'(r_sum), 32'h00000002);
    check("rst_next_cout", 32'(r_cout), 32'd0);
    check("rst_next_latency", 32'(lat), 32'(NCHUNK));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
